// File: rtl/id_stage_module.sv
// ARM decode stage with 15-entry register file and ID/EX pipeline register.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writeback data into val_rn/val_rm.
module id_stage_module #(
    parameter int unsigned WORD_LENGTH = 32,
    parameter int unsigned REG_COUNT   = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   flush,
    input  logic [WORD_LENGTH-1:0] pc_in,
    input  logic [31:0]            instruction_in,
    input  logic [3:0]             status_in,
    input  logic                   wb_en_in,
    input  logic [3:0]             wb_dest,
    input  logic [WORD_LENGTH-1:0] wb_value,
    output logic [3:0]             src1,
    output logic [3:0]             src2,
    output logic                   two_src,
    output logic [WORD_LENGTH-1:0] pc_out,
    output logic [WORD_LENGTH-1:0] val_rn,
    output logic [WORD_LENGTH-1:0] val_rm,
    output logic                   imm,
    output logic [11:0]            shift_operand,
    output logic [23:0]            signed_imm_24,
    output logic [3:0]             dest,
    output logic [3:0]             exe_cmd,
    output logic                   mem_r_en,
    output logic                   mem_w_en,
    output logic                   wb_en,
    output logic                   b,
    output logic                   s
);

    logic [WORD_LENGTH-1:0] rf [REG_COUNT];

    logic [3:0] cond;
    logic [1:0] mode;
    logic       i_bit;
    logic [3:0] opcode;
    logic       s_bit;
    logic       is_str;
    logic       flag_n, flag_z, flag_c, flag_v;

    assign cond   = instruction_in[31:28];
    assign mode   = instruction_in[27:26];
    assign i_bit  = instruction_in[25];
    assign opcode = instruction_in[24:21];
    assign s_bit  = instruction_in[20];
    assign {flag_n, flag_z, flag_c, flag_v} = status_in;

    assign is_str  = (mode == 2'b01) && !s_bit;
    assign src1    = instruction_in[19:16];
    assign src2    = is_str ? instruction_in[15:12] : instruction_in[3:0];
    assign two_src = !i_bit || is_str;

    function automatic logic [WORD_LENGTH-1:0] rf_read(input logic [3:0] idx);
        if (int'(idx) < int'(REG_COUNT)) begin
            return rf[idx];
        end
        return '0;
    endfunction

    logic [WORD_LENGTH-1:0] rn_read;
    logic [WORD_LENGTH-1:0] rm_read;

`ifdef ID_WB_BYPASS_EN
    assign rn_read = (wb_en_in && wb_dest == src1 && wb_dest != 4'hf) ? wb_value : rf_read(src1);
    assign rm_read = (wb_en_in && wb_dest == src2 && wb_dest != 4'hf) ? wb_value : rf_read(src2);
`else
    assign rn_read = rf_read(src1);
    assign rm_read = rf_read(src2);
`endif

    logic cond_ok;

    always_comb begin
        cond_ok = 1'b0;
        unique case (cond)
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = !flag_z;
            4'b0010: cond_ok = flag_c;
            4'b0011: cond_ok = !flag_c;
            4'b0100: cond_ok = flag_n;
            4'b0101: cond_ok = !flag_n;
            4'b0110: cond_ok = flag_v;
            4'b0111: cond_ok = !flag_v;
            4'b1000: cond_ok = flag_c && !flag_z;
            4'b1001: cond_ok = !flag_c || flag_z;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1100: cond_ok = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ok = flag_z || (flag_n != flag_v);
            4'b1110: cond_ok = 1'b1;
            4'b1111: cond_ok = 1'b0;
        endcase
    end

    logic [3:0] exe_cmd_c;
    logic       mem_r_c, mem_w_c, wb_c, b_c, s_c, dec_ok;

    always_comb begin
        exe_cmd_c = 4'b0000;
        mem_r_c   = 1'b0;
        mem_w_c   = 1'b0;
        wb_c      = 1'b0;
        b_c       = 1'b0;
        s_c       = 1'b0;
        dec_ok    = 1'b0;
        case (mode)
            2'b00: begin
                dec_ok = 1'b1;
                wb_c   = 1'b1;
                s_c    = s_bit;
                case (opcode)
                    4'b0000: exe_cmd_c = 4'b0110;
                    4'b0001: exe_cmd_c = 4'b1000;
                    4'b0010: exe_cmd_c = 4'b0100;
                    4'b0100: exe_cmd_c = 4'b0010;
                    4'b0101: exe_cmd_c = 4'b0011;
                    4'b0110: exe_cmd_c = 4'b0101;
                    4'b1000: begin
                        exe_cmd_c = 4'b0110;
                        wb_c      = 1'b0;
                    end
                    4'b1010: begin
                        exe_cmd_c = 4'b0100;
                        wb_c      = 1'b0;
                    end
                    4'b1100: exe_cmd_c = 4'b0111;
                    4'b1101: exe_cmd_c = 4'b0001;
                    4'b1111: exe_cmd_c = 4'b1001;
                    default: dec_ok = 1'b0;
                endcase
            end
            2'b01: begin
                dec_ok    = 1'b1;
                exe_cmd_c = 4'b0010;
                mem_r_c   = s_bit;
                wb_c      = s_bit;
                mem_w_c   = !s_bit;
            end
            2'b10: begin
                dec_ok = 1'b1;
                b_c    = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
        // Failed condition or undefined encoding both become a bubble.
        if (!(dec_ok && cond_ok)) begin
            exe_cmd_c = 4'b0000;
            mem_r_c   = 1'b0;
            mem_w_c   = 1'b0;
            wb_c      = 1'b0;
            b_c       = 1'b0;
            s_c       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(REG_COUNT); k++) begin
                rf[k] <= '0;
            end
        end else if (wb_en_in && int'(wb_dest) < int'(REG_COUNT)) begin
            rf[wb_dest] <= wb_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            pc_out        <= '0;
            val_rn        <= '0;
            val_rm        <= '0;
            imm           <= 1'b0;
            shift_operand <= '0;
            signed_imm_24 <= '0;
            dest          <= '0;
            exe_cmd       <= '0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            wb_en         <= 1'b0;
            b             <= 1'b0;
            s             <= 1'b0;
        end else begin
            pc_out        <= pc_in;
            val_rn        <= rn_read;
            val_rm        <= rm_read;
            imm           <= i_bit;
            shift_operand <= instruction_in[11:0];
            signed_imm_24 <= instruction_in[23:0];
            dest          <= instruction_in[15:12];
            exe_cmd       <= freeze ? 4'b0000 : exe_cmd_c;
            mem_r_en      <= freeze ? 1'b0 : mem_r_c;
            mem_w_en      <= freeze ? 1'b0 : mem_w_c;
            wb_en         <= freeze ? 1'b0 : wb_c;
            b             <= freeze ? 1'b0 : b_c;
            s             <= freeze ? 1'b0 : s_c;
        end
    end

endmodule

// File: tb/tb_id_stage_module.sv
// Directed-vector bench for id_stage_module; honours ID_WB_BYPASS_EN when defined.
module tb_id_stage_module;

    logic        clk = 1'b0;
    logic        rst, freeze, flush;
    logic [31:0] pc_in, instruction_in, wb_value;
    logic [3:0]  status_in, wb_dest;
    logic        wb_en_in;
    logic [3:0]  src1, src2;
    logic        two_src;
    logic [31:0] pc_out, val_rn, val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest, exe_cmd;
    logic        mem_r_en, mem_w_en, wb_en, b, s;

    int total = 0;
    int bad   = 0;

    id_stage_module dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .pc_in(pc_in), .instruction_in(instruction_in), .status_in(status_in),
        .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
        .src1(src1), .src2(src2), .two_src(two_src),
        .pc_out(pc_out), .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
        .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest(dest),
        .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_en(wb_en), .b(b), .s(s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] idx, input logic [31:0] val);
        wb_en_in = 1'b1;
        wb_dest  = idx;
        wb_value = val;
        step();
        wb_en_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        pc_in = 32'h0; instruction_in = 32'hE0813002; status_in = 4'b0000;
        wb_en_in = 1'b0; wb_dest = 4'h0; wb_value = 32'h0;
        step();
        step();
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_exe_cmd", 32'(exe_cmd), 32'h0);
        check("rst_wb_en", 32'(wb_en), 32'h0);
        check("rst_src1", 32'(src1), 32'h1);
        check("rst_two_src", 32'(two_src), 32'h1);
        rst = 1'b0;

        instruction_in = 32'h0;
        write_reg(4'h1, 32'd5);
        write_reg(4'h2, 32'd7);

        instruction_in = 32'hE0813002; pc_in = 32'h100;
        step();
        check("add_exe_cmd", 32'(exe_cmd), 32'h2);
        check("add_wb_en", 32'(wb_en), 32'h1);
        check("add_val_rn", val_rn, 32'd5);
        check("add_val_rm", val_rm, 32'd7);
        check("add_dest", 32'(dest), 32'h3);
        check("add_pc_out", pc_out, 32'h100);

        instruction_in = 32'h03A01001;
        step();
        check("moveq_exe_cmd", 32'(exe_cmd), 32'h0);
        check("moveq_wb_en", 32'(wb_en), 32'h0);
        check("moveq_imm", 32'(imm), 32'h1);
        instruction_in = 32'h13A01001;
        step();
        check("movne_exe_cmd", 32'(exe_cmd), 32'h1);
        check("movne_wb_en", 32'(wb_en), 32'h1);

        instruction_in = 32'hE5812000;
        #1;
        check("str_src2", 32'(src2), 32'h2);
        check("str_two_src", 32'(two_src), 32'h1);
        step();
        check("str_mem_w_en", 32'(mem_w_en), 32'h1);
        check("str_wb_en", 32'(wb_en), 32'h0);
        check("str_val_rm", val_rm, 32'd7);

        instruction_in = 32'hEA000004;
        step();
        check("br_b", 32'(b), 32'h1);
        check("br_imm24", 32'(signed_imm_24), 32'h000004);
        check("br_exe_cmd", 32'(exe_cmd), 32'h0);

        instruction_in = 32'hE1510002; // CMP R1,R2 with S set
        step();
        check("cmp_exe_cmd", 32'(exe_cmd), 32'h4);
        check("cmp_wb_en", 32'(wb_en), 32'h0);
        check("cmp_s", 32'(s), 32'h1);

        instruction_in = 32'hE0613002; // RSB is not decoded
        step();
        check("rsb_bubble", 32'(exe_cmd), 32'h0);

        status_in = 4'b1000; // N=1, V=0
        instruction_in = 32'hA0813002;
        step();
        check("ge_bubble", 32'(wb_en), 32'h0);
        instruction_in = 32'hB0813002;
        step();
        check("lt_taken", 32'(exe_cmd), 32'h2);
        instruction_in = 32'hF0813002;
        step();
        check("nv_bubble", 32'(wb_en), 32'h0);
        status_in = 4'b0000;

        write_reg(4'hF, 32'hDEAD);
        instruction_in = 32'hE081300F;
        step();
        check("r15_reads_zero", val_rm, 32'h0);

        instruction_in = 32'hE0813002; pc_in = 32'h200; freeze = 1'b1;
        step();
        check("frz_exe_cmd", 32'(exe_cmd), 32'h0);
        check("frz_wb_en", 32'(wb_en), 32'h0);
        check("frz_pc_out", pc_out, 32'h200);
        check("frz_val_rn", val_rn, 32'd5);
        flush = 1'b1;
        step();
        check("fl_pc_out", pc_out, 32'h0);
        check("fl_val_rn", val_rn, 32'h0);
        check("fl_dest", 32'(dest), 32'h0);
        freeze = 1'b0; flush = 1'b0;

        instruction_in = 32'hE0845002; // ADD R5,R4,R2
        wb_en_in = 1'b1; wb_dest = 4'h4; wb_value = 32'd9;
        step();
        wb_en_in = 1'b0;
`ifdef ID_WB_BYPASS_EN
        check("bypass_val_rn", val_rn, 32'd9);
`else
        check("bypass_val_rn", val_rn, 32'd0);
`endif
        step();
        check("r4_after_write", val_rn, 32'd9);

        instruction_in = 32'hE0813002; pc_in = 32'h300;
        step();
        check("pre_rst_pc_out", pc_out, 32'h300);
        rst = 1'b1;
        #1;
        check("midrst_pc_out", pc_out, 32'h0);
        check("midrst_val_rn", val_rn, 32'h0);
        check("midrst_wb_en", 32'(wb_en), 32'h0);
        #1;
        rst = 1'b0;
        step();
        check("post_rst_rf_r1", val_rn, 32'h0);
        check("post_rst_exe_cmd", 32'(exe_cmd), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
